victim_tag_store: RTL and testbench



---
 rtl/victim_tag_store.sv | 137 +++++++++++++
 tb/tb_victim_tag_store.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/victim_tag_store.sv
// victim_tag_store
//   Tag/valid/dirty array for the victim cache, one entry per way, held in
//   flops. Supports indexed write, indexed read, fully associative lookup
//   by tag, and per-way valid/dirty maintenance. Read and lookup results
//   are registered and hold until the next read_en / lookup_en.
//
// Ports
//   clk, rst_n      rising-edge clock, synchronous active-low reset
//   write_en        tag[way] <- tag_in, valid <- 1, dirty <- 0
//   read_en         capture entry of way_index_in into *_read outputs
//   lookup_en       search all valid ways for tag_in
//   tag_in          tag for write or lookup
//   way_index_in    target way for write/read/valid_clear/dirty_set/dirty_clear
//   valid_clear     valid <- 0, dirty <- 0 (tag kept)
//   dirty_set       dirty <- 1 (independent of valid)
//   dirty_clear     dirty <- 0
//   hit             result of last lookup
//   hit_way_index   lowest matching way of last lookup (0 on miss)
//   valid_read      valid bit from last read
//   dirty_read      dirty bit from last read
//   tag_read        tag from last read
module victim_tag_store #(
    parameter int unsigned TAG_WIDTH = 4,
    parameter int unsigned NUM_WAYS  = 4,
    localparam int unsigned W        = $clog2(NUM_WAYS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 write_en,
    input  logic                 read_en,
    input  logic                 lookup_en,
    input  logic [TAG_WIDTH-1:0] tag_in,
    input  logic [W-1:0]         way_index_in,
    input  logic                 valid_clear,
    input  logic                 dirty_set,
    input  logic                 dirty_clear,
    output logic                 hit,
    output logic [W-1:0]         hit_way_index,
    output logic                 valid_read,
    output logic                 dirty_read,
    output logic [TAG_WIDTH-1:0] tag_read
);

    logic [TAG_WIDTH-1:0] tag_q [NUM_WAYS];
    logic [TAG_WIDTH-1:0] tag_d [NUM_WAYS];
    logic [NUM_WAYS-1:0]  valid_q, valid_d;
    logic [NUM_WAYS-1:0]  dirty_q, dirty_d;

    logic                 hit_q, hit_d;
    logic [W-1:0]         hit_way_q, hit_way_d;
    logic                 valid_read_q, valid_read_d;
    logic                 dirty_read_q, dirty_read_d;
    logic [TAG_WIDTH-1:0] tag_read_q, tag_read_d;

    logic                 match_any;
    logic [W-1:0]         match_idx;

    // Array update: one op per way per cycle, valid_clear > write > dirty_clear > dirty_set.
    always_comb begin
        tag_d   = tag_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (valid_clear) begin
            valid_d[way_index_in] = 1'b0;
            dirty_d[way_index_in] = 1'b0;
        end else if (write_en) begin
            tag_d[way_index_in]   = tag_in;
            valid_d[way_index_in] = 1'b1;
            dirty_d[way_index_in] = 1'b0;
        end else if (dirty_clear) begin
            dirty_d[way_index_in] = 1'b0;
        end else if (dirty_set) begin
            dirty_d[way_index_in] = 1'b1;
        end
    end

    // Associative match on the pre-edge array; first match found wins so
    // the reported way is the lowest index.
    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        for (int unsigned i = 0; i < NUM_WAYS; i++) begin
            if (!match_any && valid_q[i] && (tag_q[i] == tag_in)) begin
                match_any = 1'b1;
                match_idx = W'(i);
            end
        end
    end

    always_comb begin
        hit_d        = hit_q;
        hit_way_d    = hit_way_q;
        valid_read_d = valid_read_q;
        dirty_read_d = dirty_read_q;
        tag_read_d   = tag_read_q;
        if (lookup_en) begin
            hit_d     = match_any;
            hit_way_d = match_idx;
        end
        if (read_en) begin
            valid_read_d = valid_q[way_index_in];
            dirty_read_d = dirty_q[way_index_in];
            tag_read_d   = tag_q[way_index_in];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_WAYS; i++) begin
                tag_q[i] <= '0;
            end
            valid_q      <= '0;
            dirty_q      <= '0;
            hit_q        <= 1'b0;
            hit_way_q    <= '0;
            valid_read_q <= 1'b0;
            dirty_read_q <= 1'b0;
            tag_read_q   <= '0;
        end else begin
            tag_q        <= tag_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            hit_q        <= hit_d;
            hit_way_q    <= hit_way_d;
            valid_read_q <= valid_read_d;
            dirty_read_q <= dirty_read_d;
            tag_read_q   <= tag_read_d;
        end
    end

    assign hit           = hit_q;
    assign hit_way_index = hit_way_q;
    assign valid_read    = valid_read_q;
    assign dirty_read    = dirty_read_q;
    assign tag_read      = tag_read_q;

endmodule

// File: tb/tb_victim_tag_store.sv
// Testbench for victim_tag_store: directed test-plan sequence with constant
// expectations, then randomized traffic; every cycle the DUT outputs are
// compared to a behavioural model of the tag store.
module tb_victim_tag_store;

    localparam int unsigned TW = 4;
    localparam int unsigned NW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          write_en, read_en, lookup_en;
    logic [TW-1:0] tag_in;
    logic [1:0]    way_index_in;
    logic          valid_clear, dirty_set, dirty_clear;
    logic          hit;
    logic [1:0]    hit_way_index;
    logic          valid_read, dirty_read;
    logic [TW-1:0] tag_read;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    int  m_tag   [NW];
    bit  m_valid [NW];
    bit  m_dirty [NW];
    bit  m_hit;
    int  m_hw;
    bit  m_vr, m_dr;
    int  m_tr;

    victim_tag_store #(.TAG_WIDTH(TW), .NUM_WAYS(NW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .write_en      (write_en),
        .read_en       (read_en),
        .lookup_en     (lookup_en),
        .tag_in        (tag_in),
        .way_index_in  (way_index_in),
        .valid_clear   (valid_clear),
        .dirty_set     (dirty_set),
        .dirty_clear   (dirty_clear),
        .hit           (hit),
        .hit_way_index (hit_way_index),
        .valid_read    (valid_read),
        .dirty_read    (dirty_read),
        .tag_read      (tag_read)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic idle();
        write_en = 0; read_en = 0; lookup_en = 0; valid_clear = 0;
        dirty_set = 0; dirty_clear = 0; tag_in = '0; way_index_in = '0;
    endtask

    // One clock: model consumes the sampled inputs, then all outputs compared.
    task automatic tick();
        int w;
        @(posedge clk);
        w = int'(way_index_in);
        if (!rst_n) begin
            for (int i = 0; i < NW; i++) begin
                m_tag[i] = 0; m_valid[i] = 0; m_dirty[i] = 0;
            end
            m_hit = 0; m_hw = 0; m_vr = 0; m_dr = 0; m_tr = 0;
        end else begin
            if (read_en) begin
                m_vr = m_valid[w]; m_dr = m_dirty[w]; m_tr = m_tag[w];
            end
            if (lookup_en) begin
                m_hit = 0; m_hw = 0;
                for (int i = NW - 1; i >= 0; i--)
                    if (m_valid[i] && m_tag[i] == int'(tag_in)) begin
                        m_hit = 1; m_hw = i;
                    end
            end
            if (valid_clear) begin
                m_valid[w] = 0; m_dirty[w] = 0;
            end else if (write_en) begin
                m_tag[w] = int'(tag_in); m_valid[w] = 1; m_dirty[w] = 0;
            end else if (dirty_clear) begin
                m_dirty[w] = 0;
            end else if (dirty_set) begin
                m_dirty[w] = 1;
            end
        end
        #1;
        check("model_hit",  32'(hit),           32'(m_hit));
        check("model_hway", 32'(hit_way_index), 32'(m_hw));
        check("model_vrd",  32'(valid_read),    32'(m_vr));
        check("model_drd",  32'(dirty_read),    32'(m_dr));
        check("model_trd",  32'(tag_read),      32'(m_tr));
    endtask

    task automatic do_write(input int w, input int t);
        idle(); write_en = 1; way_index_in = 2'(w); tag_in = TW'(t); tick(); idle();
    endtask

    task automatic do_read(input int w);
        idle(); read_en = 1; way_index_in = 2'(w); tick(); idle();
    endtask

    task automatic do_lookup(input int t);
        idle(); lookup_en = 1; tag_in = TW'(t); tick(); idle();
    endtask

    task automatic do_maint(input int w, input bit vc, input bit ds, input bit dc);
        idle(); way_index_in = 2'(w); valid_clear = vc; dirty_set = ds; dirty_clear = dc;
        tick(); idle();
    endtask

    initial begin
        idle();
        rst_n = 0;
        tick(); tick();
        rst_n = 1;

        // Reset state
        check("rst_hit", 32'(hit), 0);
        for (int w = 0; w < 4; w++) begin
            do_read(w);
            check("rst_tag", 32'(tag_read), 0);
            check("rst_valid", 32'(valid_read), 0);
            check("rst_dirty", 32'(dirty_read), 0);
        end

        // Writes and reads
        do_write(0, 'hA); do_write(1, 'hB); do_write(2, 'hC);
        do_read(0); check("rd0_tag", 32'(tag_read), 'hA); check("rd0_v", 32'(valid_read), 1);
        check("rd0_d", 32'(dirty_read), 0);
        do_read(1); check("rd1_tag", 32'(tag_read), 'hB); check("rd1_v", 32'(valid_read), 1);
        do_read(2); check("rd2_tag", 32'(tag_read), 'hC); check("rd2_v", 32'(valid_read), 1);
        do_read(3); check("rd3_v", 32'(valid_read), 0);

        // Lookups
        do_lookup('hB); check("lkB_hit", 32'(hit), 1); check("lkB_way", 32'(hit_way_index), 1);
        do_lookup('hC); check("lkC_hit", 32'(hit), 1); check("lkC_way", 32'(hit_way_index), 2);
        do_lookup('hF); check("lkF_hit", 32'(hit), 0); check("lkF_way", 32'(hit_way_index), 0);

        // Dirty maintenance
        do_maint(1, 0, 1, 0); do_read(1); check("dset", 32'(dirty_read), 1);
        do_maint(1, 0, 0, 1); do_read(1); check("dclr", 32'(dirty_read), 0);
        do_maint(1, 0, 1, 1); do_read(1); check("dset_clr", 32'(dirty_read), 0);

        // valid_clear keeps tag, drops valid and dirty
        do_maint(1, 0, 1, 0);
        do_maint(1, 1, 0, 0);
        do_read(1);
        check("vclr_v", 32'(valid_read), 0); check("vclr_d", 32'(dirty_read), 0);
        check("vclr_tag", 32'(tag_read), 'hB);
        do_lookup('hB); check("vclr_lk", 32'(hit), 0);

        // Lowest matching way wins
        do_write(1, 5); do_write(3, 5);
        do_lookup(5); check("multi_hit", 32'(hit), 1); check("multi_way", 32'(hit_way_index), 1);

        // Same-cycle write + lookup sees pre-edge array
        idle(); write_en = 1; lookup_en = 1; way_index_in = 0; tag_in = 9; tick(); idle();
        check("wr_lk_same", 32'(hit), 0);
        do_lookup(9); check("wr_lk_next", 32'(hit), 1); check("wr_lk_way", 32'(hit_way_index), 0);

        // Same-cycle write + read returns old entry
        idle(); write_en = 1; read_en = 1; way_index_in = 2; tag_in = 3; tick(); idle();
        check("wr_rd_same", 32'(tag_read), 'hC);

        // valid_clear beats write on the same way
        idle(); write_en = 1; valid_clear = 1; way_index_in = 3; tag_in = 7; tick(); idle();
        do_read(3); check("vc_over_wr", 32'(valid_read), 0);

        // Reset during a write leaves the array cleared
        idle(); rst_n = 0; write_en = 1; way_index_in = 2; tag_in = 7; tick(); idle();
        rst_n = 1;
        for (int w = 0; w < 4; w++) begin
            do_read(w);
            check("rstwr_v", 32'(valid_read), 0);
            check("rstwr_tag", 32'(tag_read), 0);
        end
        do_lookup(7); check("rstwr_lk", 32'(hit), 0);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            rst_n        = ($urandom_range(0, 79) != 0);
            write_en     = ($urandom_range(0, 2) == 0);
            read_en      = ($urandom_range(0, 1) == 0);
            lookup_en    = ($urandom_range(0, 1) == 0);
            valid_clear  = ($urandom_range(0, 6) == 0);
            dirty_set    = ($urandom_range(0, 3) == 0);
            dirty_clear  = ($urandom_range(0, 4) == 0);
            tag_in       = TW'($urandom_range(0, 5));
            way_index_in = 2'($urandom_range(0, 3));
            tick();
        end
        idle();
        rst_n = 1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
